// File: rtl/alu_share_ctrl.sv
// Two-requester sequencer sharing one ALU: round-robin accept,
// fixed-latency wait, registered response with zero/negative flags.
module alu_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  localparam logic [2:0] LAT = 3'(LATENCY);

  state_t     state;
  state_t     state_nx;
  logic       ptr;
  logic       id_q;
  logic [2:0] cnt;
  logic       g0;
  logic       g1;
  logic       accept;
  logic       last;

  // ptr holds the last winner; the other side has priority
  assign g0 = req0_valid && (ptr || !req1_valid);
  assign g1 = req1_valid && (!ptr || !req0_valid);

  assign req0_ready = (state == IDLE) && rst_n && g0;
  assign req1_ready = (state == IDLE) && rst_n && g1;

  assign accept = req0_ready || req1_ready;
  assign last   = (state == BUSY) && (cnt == 3'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = HOLD;
      HOLD:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
    end else begin
      state  <= state_nx;
      alu_en <= accept;
      if (accept) begin
        alu_a  <= req1_ready ? req1_a : req0_a;
        alu_b  <= req1_ready ? req1_b : req0_b;
        alu_op <= req1_ready ? req1_op : req0_op;
        id_q   <= req1_ready;
        ptr    <= req1_ready;
        cnt    <= LAT;
      end
      if (state == BUSY) cnt <= cnt - 3'd1;
      if (last) begin
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == '0);
        rsp_neg    <= alu_result[WIDTH-1];
        rsp_id     <= id_q;
        rsp_valid  <= 1'b1;
      end
      if (state == HOLD && rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural
// fixed-latency ALU model on the alu_* side.
module tb_alu_share_ctrl;

  localparam int W   = 32;
  localparam int LAT = 2;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [1:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   req1_op;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic         alu_en;
  logic [W-1:0] alu_result;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_neg;

  int npass = 0;
  int ntot  = 0;

  alu_share_ctrl #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg)
  );

  always #5 clk = ~clk;

  // result is garbage until LAT-1 cycles after the pulse cycle
  int           acnt = 0;
  logic [W-1:0] amod;
  always @(posedge clk) begin
    if (alu_en) acnt <= 1;
    else if (acnt != 0 && acnt < 15) acnt <= acnt + 1;
  end
  always_comb begin
    amod = '0;
    case (alu_op)
      OP_AND:  amod = alu_a & alu_b;
      OP_ADD:  amod = alu_a + alu_b;
      OP_SUB:  amod = alu_a - alu_b;
      default: amod = '0;
    endcase
    alu_result = (!alu_en && acnt >= 1 && acnt >= LAT - 1)
                 ? amod : 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
    chk({tag, "_alu"}, {alu_en, alu_op, alu_a}, 0);
    chk({tag, "_alub"}, alu_b, 0);
    chk({tag, "_rsp"},
        {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_result}, 0);
  endtask

  task automatic do_op(input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] op,
                       input logic [W-1:0] er, input bit ez,
                       input bit en);
    rsp_ready = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1 chk("op_ready", {req1_ready, req0_ready},
           id ? 64'd2 : 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 chk("op_en", {alu_en, rsp_valid}, 2'b10);
    chk("op_alu_op", alu_op, op);
    chk("op_alu_a", alu_a, a);
    chk("op_alu_b", alu_b, b);
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);
      #1 chk("op_busy", {alu_en, rsp_valid}, 0);
    end
    @(negedge clk);
    #1 chk("op_rsp_valid", rsp_valid, 1);
    chk("op_result", rsp_result, er);
    chk("op_id_z_n", {rsp_id, rsp_zero, rsp_neg}, {id, ez, en});
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("op_release", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int gid[4];
    int gcyc[4];
    int rid[4];
    int ng, nr, both, cyc, waited, seen;

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'h33; req1_b = 32'h44; req1_op = OP_SUB;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk_zero("reset");
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    do_op(1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0);
    do_op(1'b1, 32'd3, 32'd5, OP_SUB, 32'hFFFFFFFE, 1'b0, 1'b1);
    do_op(1'b0, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1, 1'b0);
    do_op(1'b1, 32'h1234, 32'h5678, OP_NOP, 32'd0, 1'b1, 1'b0);

    // both requesters contend, consumer always ready
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'hF; req1_b = 32'h3; req1_op = OP_AND;
    rsp_ready = 1'b1;
    ng = 0; nr = 0; both = 0; cyc = 0;
    while (nr < 4 && cyc < 40) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if ((req0_ready || req1_ready) && ng < 4) begin
        gid[ng] = int'(req1_ready);
        gcyc[ng] = cyc;
        ng++;
      end
      if (rsp_valid && nr < 4) begin
        rid[nr] = int'(rsp_id);
        nr++;
      end
      @(negedge clk);
      cyc++;
      if (ng == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    chk("arb_grants", 64'(ng), 4);
    chk("arb_rsps", 64'(nr), 4);
    chk("arb_both", 64'(both), 0);
    if (ng == 4 && nr == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("arb_gid", 64'(gid[i]), 64'(i % 2));
        chk("arb_rid", 64'(rid[i]), 64'(i % 2));
      end
      for (int i = 1; i < 4; i++)
        chk("arb_gap", 64'(gcyc[i] - gcyc[i-1]), LAT + 2);
    end
    rsp_ready = 1'b0;
    @(negedge clk);

    // backpressure with a second request waiting
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = OP_ADD;
    #1 chk("bp_ready0", {req1_ready, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFF; req1_b = 32'h0F; req1_op = OP_AND;
    waited = 0;
    #1;
    while (!rsp_valid && waited < 10) begin
      @(negedge clk);
      #1 waited++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_result},
          {4'b1000, 32'd5});
      chk("bp_noready", {req1_ready, req0_ready}, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_idle", {rsp_valid, req1_ready, req0_ready}, 3'b010);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 chk("bp_next_en", {alu_en, alu_op}, {1'b1, OP_AND});
    waited = 0;
    while (!rsp_valid && waited < 10) begin
      @(negedge clk);
      #1 waited++;
    end
    chk("bp_next_rsp", {rsp_valid, rsp_id, rsp_result},
        {2'b11, 32'h0F});
    @(negedge clk);
    rsp_ready = 1'b0;

    // reset while the ALU is busy
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = OP_ADD;
    #1 chk("mr_ready0", {req1_ready, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero("mr_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      #1 if (rsp_valid || alu_en) seen++;
    end
    chk("mr_no_rsp", 64'(seen), 0);
    do_op(1'b1, 32'hF0F0, 32'hFF00, OP_AND, 32'hF000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // alu_en must never pulse while reset is held
  always @(negedge clk) begin
    if (!rst_n && alu_en) chk("rst_alu_en", alu_en, 0);
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitrated sequencer that shares the single-cycle-issue ALU datapath between two requesters: requester 0 is the execute stage, requester 1 is the branch/address-compare unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU operands, opcode and enable. It waits a fixed ALU latency, captures the result with zero/negative flags, and holds the response until the consumer takes it. The block sits between the decode/control logic and the ALU instance; the ALU itself is outside this block.

## Interface
- WIDTH, 32, operand/result width.
- LATENCY, 2, cycles from the alu_en pulse to a stable alu_result; legal range 1..7.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted on this edge when valid&&ready.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  2  opcode: ALU_AND, ALU_ADD, ALU_SUB; the fourth code yields 0.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_en  out  1  one-cycle start pulse to the ALU.
- alu_result  in  WIDTH  ALU output.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_neg  out  1  rsp_result[WIDTH-1].

## Operation
- FSM states: IDLE, BUSY, HOLD. Reset state is IDLE.
- IDLE:
  - Grant goes to one valid requester by round-robin. The last-grant pointer resets to 1, so req0 wins the first contest.
  - reqN_ready = (state==IDLE) && rst_n && grant==N. It is combinational and is never high for both requesters.
  - On an accept edge: latch operands, op and id into alu_a/alu_b/alu_op and the id register; toggle the pointer to the winner; go to BUSY.
- BUSY:
  - Lasts exactly LATENCY cycles; a down-counter is loaded with LATENCY on entry.
  - alu_en = 1 in the first BUSY cycle only.
  - alu_a/alu_b/alu_op stay stable for the whole BUSY period.
  - On the last BUSY edge: capture rsp_result = alu_result, compute rsp_zero and rsp_neg from the captured value, set rsp_valid, go to HOLD.
- HOLD:
  - rsp_* outputs stay stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE. No accept happens in the same cycle.
- Requesters keep valid, operands and op stable until ready. Their behaviour otherwise is undefined, and the block does not check it.
- The unused opcode is passed through unchanged. The expected result is 0 with rsp_zero = 1.
- Reset (rst_n low, any state):
  - State goes to IDLE and the pointer to 1.
  - alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_id, rsp_result, rsp_zero and rsp_neg all go to 0.
  - Both readies are 0 while rst_n is low.
  - An in-flight operation is discarded; no response is ever produced for it.

## Timing
- Accept edge ends cycle 0. alu_en is high in cycle 1. rsp_valid rises in cycle LATENCY+1.
- Minimum issue period is LATENCY+2 cycles per operation, reached with rsp_ready tied high.
- No combinational path from req*_a/b/op or alu_result to any output; all of them are registered.
- The only combinational outputs are req*_ready, derived from state, pointer, req*_valid and rst_n.
- Reset assertion takes effect immediately (asynchronous). Deassertion is synchronised externally; the first accept can happen on the first edge after deassertion.

## Test plan
- Reset: hold rst_n low with both valids high -> every output is 0, both readies are 0, and no alu_en is seen.
- Single op, LATENCY=2: req0 ALU_ADD 5+7 -> ready0 in cycle 0, alu_en only in cycle 1, rsp_valid in cycle 3, rsp_result=12, rsp_id=0, zero=0, neg=0.
- Flags: req1 ALU_SUB 3-5 -> result 0xFFFFFFFE, neg=1, id=1. ALU_SUB 9-9 -> result 0, zero=1. Unused opcode -> result 0, zero=1.
- Arbitration: both valids held high, rsp_ready=1 -> grant order 0,1,0,1. Each issue is 4 cycles apart, readies are never simultaneous, and rsp_id alternates.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_* stay constant and no ready is asserted. Raising rsp_ready -> IDLE next cycle, then the next accept.
- Reset mid-BUSY: assert rst_n in cycle 2 of an ADD -> outputs are 0 immediately and no response appears. After release, a new req1 AND 0xF0F0&0xFF00 -> result 0xF000, id=1.
